gpio_in_conditioner: RTL and testbench



---
 rtl/gpio_pkg.sv | 14 +
 rtl/gpio_in_conditioner_if.sv | 24 ++
 rtl/gpio_debounce_bit.sv | 68 ++++++
 rtl/gpio_in_conditioner.sv | 80 ++++++++
 tb/tb_gpio_in_conditioner.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO types and parity helper, reused by the AHB GPIO peripheral.
package gpio_pkg;

  localparam int GPIO_WIDTH = 16;

  typedef logic [GPIO_WIDTH-1:0] gpio_data_t;
  typedef logic [GPIO_WIDTH:0]   gpio_bus_t;

  // paritysel = 1 selects odd parity, 0 selects even parity
  function automatic logic gpio_parity(input gpio_data_t data, input logic paritysel);
    return (^data) ^ paritysel;
  endfunction

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// Pin-side and GPIO-side signals of the input conditioner.
// PARITY_INJ exists only when GPIO_PARITY_INJECT_EN is defined.
interface gpio_in_conditioner_if;
  import gpio_pkg::*;

  gpio_data_t PINS_IN;
  logic       PARITYSEL;
  gpio_bus_t  GPIOIN;
  logic       CHANGED;
`ifdef GPIO_PARITY_INJECT_EN
  logic       PARITY_INJ;

  modport master (output PINS_IN, output PARITYSEL, output PARITY_INJ,
                  input GPIOIN, input CHANGED);
  modport slave  (input PINS_IN, input PARITYSEL, input PARITY_INJ,
                  output GPIOIN, output CHANGED);
`else
  modport master (output PINS_IN, output PARITYSEL,
                  input GPIOIN, input CHANGED);
  modport slave  (input PINS_IN, input PARITYSEL,
                  output GPIOIN, output CHANGED);
`endif

endinterface

// File: rtl/gpio_debounce_bit.sv
// One pin: synchroniser chain, tick-gated run counter and debounced flop.
// deb_next exposes the value deb takes at the coming edge.
module gpio_debounce_bit #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic pin,
  input  logic tick,
  output logic deb_next,
  output logic deb
);

  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_next_s;
  logic                   deb_r;
  logic                   deb_next_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain; stage 0 samples the asynchronous pin
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
    end
  end

  // Count consecutive ticks that disagree with deb; flip on the last one
  always_comb begin
    cnt_next_s = cnt_r;
    deb_next_s = deb_r;
    if (tick) begin
      if (sync_s == deb_r) begin
        cnt_next_s = '0;
      end else if (cnt_r == CNT_LAST) begin
        deb_next_s = sync_s;
        cnt_next_s = '0;
      end else begin
        cnt_next_s = cnt_r + CW'(1'b1);
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Counter and debounced state
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_r <= '0;
      deb_r <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      deb_r <= deb_next_s;
    end
  end

  assign deb_next = deb_next_s;
  assign deb      = deb_r;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Synchronise, debounce and parity-tag 16 raw pins for the GPIO GPIOIN bus.
// Optional macro GPIO_PARITY_INJECT_EN adds PARITY_INJ to force a parity error.
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 16,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic HCLK,
  input  logic HRESETn,
  gpio_in_conditioner_if.slave gpio_io
);

  localparam int TW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DEBOUNCE_DIV - 1);

  logic [TW-1:0] tick_cnt_r;
  logic          tick_s;
  gpio_data_t    deb_next_s;
  gpio_data_t    deb_s;
  logic          parity_next_s;
  logic          parity_r;
  logic          changed_r;

  // With DEBOUNCE_DIV = 1 the counter sits at 0 and tick is constant
  assign tick_s = (tick_cnt_r == TICK_LAST);

  // Shared debounce sample tick divider
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1'b1);
    end
  end

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_bit (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .pin     (gpio_io.PINS_IN[i]),
      .tick    (tick_s),
      .deb_next(deb_next_s[i]),
      .deb     (deb_s[i])
    );
  end

  // Parity follows deb_next so it lands on the same edge as the data
  always_comb begin
    parity_next_s = gpio_parity(deb_next_s, gpio_io.PARITYSEL);
`ifdef GPIO_PARITY_INJECT_EN
    if (gpio_io.PARITY_INJ) begin
      parity_next_s = ~gpio_parity(deb_next_s, gpio_io.PARITYSEL);
    end else begin
      parity_next_s = gpio_parity(deb_next_s, gpio_io.PARITYSEL);
    end
`endif
  end

  // Parity and change-pulse registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      parity_r  <= 1'b0;
      changed_r <= 1'b0;
    end else begin
      parity_r  <= parity_next_s;
      changed_r <= (deb_next_s != deb_s);
    end
  end

  assign gpio_io.GPIOIN  = {parity_r, deb_s};
  assign gpio_io.CHANGED = changed_r;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Randomised and directed bench for two conditioner builds (DIV=4/CNT=3 and DIV=1/CNT=1).
module tb_gpio_in_conditioner;
  import gpio_pkg::*;

  localparam int SYNC = 2;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic [15:0] pins_s = 16'h0000;
  logic        psel_s = 1'b0;
  logic        inj_s  = 1'b0;

  gpio_in_conditioner_if if_a ();
  gpio_in_conditioner_if if_b ();

  assign if_a.PINS_IN   = pins_s;
  assign if_a.PARITYSEL = psel_s;
  assign if_b.PINS_IN   = pins_s;
  assign if_b.PARITYSEL = psel_s;
`ifdef GPIO_PARITY_INJECT_EN
  assign if_a.PARITY_INJ = inj_s;
  assign if_b.PARITY_INJ = inj_s;
`endif

  gpio_in_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_DIV(4), .DEBOUNCE_CNT(3)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .gpio_io(if_a.slave));
  gpio_in_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_DIV(1), .DEBOUNCE_CNT(1)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .gpio_io(if_b.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pins delayed SYNC edges, then a bit flips after CNT
  // consecutive ticks that disagree with it; ticks on every DIV-th edge.
  int          divs [2] = '{4, 1};
  int          cnts [2] = '{3, 1};
  logic [15:0] hist_m [2][SYNC];
  logic [15:0] deb_m [2];
  int          run_m [2][16];
  logic        par_m [2];
  logic        chg_m [2];
  int          edge_m;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < SYNC; s++) hist_m[d][s] = 16'h0000;
      for (int b = 0; b < 16; b++) run_m[d][b] = 0;
      deb_m[d] = 16'h0000;
      par_m[d] = 1'b0;
      chg_m[d] = 1'b0;
    end
    edge_m = 0;
  endtask

  task automatic model_edge(input logic [15:0] pins, input logic psel, input logic inj);
    logic [15:0] sync_v;
    logic [15:0] old_v;
    edge_m++;
    for (int d = 0; d < 2; d++) begin
      sync_v = hist_m[d][SYNC-1];
      for (int s = SYNC - 1; s > 0; s--) hist_m[d][s] = hist_m[d][s-1];
      hist_m[d][0] = pins;
      old_v = deb_m[d];
      if (edge_m % divs[d] == 0) begin
        for (int b = 0; b < 16; b++) begin
          if (sync_v[b] == deb_m[d][b]) begin
            run_m[d][b] = 0;
          end else begin
            run_m[d][b]++;
            if (run_m[d][b] == cnts[d]) begin
              deb_m[d][b] = sync_v[b];
              run_m[d][b] = 0;
            end
          end
        end
      end
      chg_m[d] = (deb_m[d] != old_v);
      par_m[d] = (^deb_m[d]) ^ psel ^ inj;
    end
  endtask

  task automatic compare_all();
    check_val("a_gpioin",  {15'h0, if_a.GPIOIN},  {15'h0, par_m[0], deb_m[0]});
    check_val("a_changed", {31'h0, if_a.CHANGED}, {31'h0, chg_m[0]});
    check_val("b_gpioin",  {15'h0, if_b.GPIOIN},  {15'h0, par_m[1], deb_m[1]});
    check_val("b_changed", {31'h0, if_b.CHANGED}, {31'h0, chg_m[1]});
  endtask

  // One clock: model the edge, compare 1 time unit later
  task automatic cycle();
    @(posedge HCLK);
    if (HRESETn) model_edge(pins_s, psel_s, inj_s);
    #1;
    compare_all();
  endtask

  // Assert reset between edges, check outputs clear at once, release at +3
  task automatic do_reset();
    #3;
    HRESETn = 1'b0;
    #1;
    check_val("rst_a_gpioin",  {15'h0, if_a.GPIOIN},  32'h0);
    check_val("rst_a_changed", {31'h0, if_a.CHANGED}, 32'h0);
    check_val("rst_b_gpioin",  {15'h0, if_b.GPIOIN},  32'h0);
    model_reset();
    @(posedge HCLK);
    #3;
    HRESETn = 1'b1;
  endtask

  task automatic run_measure(input int maxc, input logic [15:0] target,
                             output int first_a, output int first_b,
                             output int chg_a, output int chg_b);
    first_a = -1; first_b = -1; chg_a = 0; chg_b = 0;
    for (int i = 1; i <= maxc; i++) begin
      cycle();
      if (first_a < 0 && if_a.GPIOIN[15:0] == target) first_a = i;
      if (first_b < 0 && if_b.GPIOIN[15:0] == target) first_b = i;
      if (if_a.CHANGED) chg_a++;
      if (if_b.CHANGED) chg_b++;
    end
  endtask

  initial begin
    int fa, fb, ca, cb;
    int hold;
    logic [16:0] seen_a;
    logic        run_hit;

    HRESETn = 1'b0;
    model_reset();
    #7;
    check_val("init_a_gpioin",  {15'h0, if_a.GPIOIN},  32'h0);
    check_val("init_a_changed", {31'h0, if_a.CHANGED}, 32'h0);
    check_val("init_b_gpioin",  {15'h0, if_b.GPIOIN},  32'h0);
    @(posedge HCLK);
    @(posedge HCLK);
    #3;
    HRESETn = 1'b1;

    // Clean step to 00A5
    pins_s = 16'h00A5;
    run_measure(24, 16'h00A5, fa, fb, ca, cb);
    check_val("a5_latency_lo", {31'h0, fa >= 11}, 32'h1);
    check_val("a5_latency_hi", {31'h0, (fa > 0) && (fa <= 15)}, 32'h1);
    check_val("a5_a_chg_count", ca, 32'd1);
    check_val("a5_b_latency", fb, 32'd3);
    check_val("a5_a_final", {15'h0, if_a.GPIOIN}, {15'h0, 1'b0, 16'h00A5});

    // 5-cycle glitch on bit 0 must be rejected by the DIV=4/CNT=3 build
    pins_s = 16'h0000;
    do_reset();
    seen_a = 17'h0;
    ca = 0;
    pins_s = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      cycle();
      seen_a |= if_a.GPIOIN;
      if (if_a.CHANGED) ca++;
    end
    pins_s = 16'h0000;
    for (int i = 0; i < 30; i++) begin
      cycle();
      seen_a |= if_a.GPIOIN;
      if (if_a.CHANGED) ca++;
    end
    check_val("glitch_gpioin_seen", {15'h0, seen_a}, 32'h0);
    check_val("glitch_changed_cnt", ca, 32'd0);

    // PARITYSEL toggle with stable 0001
    pins_s = 16'h0001;
    run_measure(30, 16'h0001, fa, fb, ca, cb);
    check_val("psel_before_par", {31'h0, if_a.GPIOIN[16]}, 32'h1);
    psel_s = 1'b1;
    cycle();
    check_val("psel_after_par",  {31'h0, if_a.GPIOIN[16]}, 32'h0);
    check_val("psel_after_data", {16'h0, if_a.GPIOIN[15:0]}, 32'h0001);
    check_val("psel_after_chg",  {31'h0, if_a.CHANGED}, 32'h0);
    psel_s = 1'b0;
    cycle();

`ifdef GPIO_PARITY_INJECT_EN
    pins_s = 16'h00A5;
    run_measure(30, 16'h00A5, fa, fb, ca, cb);
    inj_s = 1'b1;
    cycle();
    check_val("inj_par_set", {31'h0, if_a.GPIOIN[16]}, 32'h1);
    inj_s = 1'b0;
    cycle();
    check_val("inj_par_clr", {31'h0, if_a.GPIOIN[16]}, 32'h0);
    check_val("inj_data",    {16'h0, if_a.GPIOIN[15:0]}, 32'h00A5);
`endif

    // Reset while a bit's run counter sits one tick short of flipping
    pins_s = 16'h0000;
    do_reset();
    for (int i = 0; i < 16; i++) cycle();
    pins_s = 16'h0008;
    run_hit = 1'b0;
    for (int i = 0; i < 40 && !run_hit; i++) begin
      cycle();
      if (run_m[0][3] == 2) run_hit = 1'b1;
    end
    check_val("midrst_run_reached", {31'h0, run_hit}, 32'h1);
    do_reset();
    run_measure(24, 16'h0008, fa, fb, ca, cb);
    check_val("midrst_restart_lo", {31'h0, fa >= 11}, 32'h1);
    check_val("midrst_restart_hi", {31'h0, (fa > 0) && (fa <= 15)}, 32'h1);

    // All-ones on the DIV=1/CNT=1 build
    pins_s = 16'h0000;
    do_reset();
    pins_s = 16'hFFFF;
    run_measure(6, 16'hFFFF, fa, fb, ca, cb);
    check_val("ffff_b_latency", fb, 32'd3);
    check_val("ffff_b_gpioin", {15'h0, if_b.GPIOIN}, {15'h0, 1'b0, 16'hFFFF});

    // Random pin activity, parity-select changes and occasional resets
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 24);
        pins_s = pins_s ^ (16'($urandom) & 16'($urandom));
      end
      hold--;
      if ($urandom_range(0, 40) == 0) psel_s = ~psel_s;
`ifdef GPIO_PARITY_INJECT_EN
      inj_s = ($urandom_range(0, 15) == 0);
`endif
      if (i == 300 || i == 550) do_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
